// File: rtl/window_fill_ctrl.sv
// window_fill_ctrl: fills the 4x16 line buffer from memory, then sweeps window index 3..15 to the MAC.
//   start/base_addr      tile request, sampled in IDLE only
//   busy/done            status; done pulses once after the last window is accepted
//   mem_rd/mem_addr      one read request per word; mem_rvalid/mem_rdata return the word
//   buf_ld/row/col/data  buffer load port, one 32-bit word per load
//   buf_index/win_valid  window sweep with win_ready handshake
//   WFC_STALL_CNT_EN     when defined, adds stall_cnt[15:0] (saturating count of stalled SWEEP cycles)
module window_fill_ctrl #(
  parameter int ADDR_W = 16,
  parameter int ROW_STRIDE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              buf_ld,
  output logic [1:0]        buf_row,
  output logic [1:0]        buf_col,
  output logic [31:0]       buf_data,
  output logic [3:0]        buf_index,
  output logic              win_valid,
  input  logic              win_ready
`ifdef WFC_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, LOAD, SWEEP, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] k_q, index_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0] data_q;
  logic [1:0] row_q, col_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? REQ : IDLE;
      REQ:     state_d = WAIT;
      WAIT:    state_d = mem_rvalid ? LOAD : WAIT;
      LOAD:    state_d = (k_q == 4'd15) ? SWEEP : REQ;
      SWEEP:   state_d = (win_ready && index_q == 4'd15) ? DONE : SWEEP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      base_q  <= '0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      index_q <= 4'd3;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        base_q <= base_addr;
        k_q    <= '0;
      end
      if (state_q == WAIT && mem_rvalid) begin
        data_q <= mem_rdata;
        row_q  <= k_q[3:2];
        col_q  <= k_q[1:0];
      end
      if (state_q == LOAD) k_q <= k_q + 4'd1;
      if (state_q == LOAD && k_q == 4'd15) index_q <= 4'd3;
      if (state_q == SWEEP && win_ready && index_q != 4'd15) index_q <= index_q + 4'd1;
    end
  end
  // Address arithmetic is ADDR_W wide on purpose so tiles near the top of memory wrap.
  assign mem_addr  = (state_q == REQ) ? base_q + ADDR_W'(k_q[3:2]) * ADDR_W'(ROW_STRIDE) + ADDR_W'(k_q[1:0]) : '0;
  assign mem_rd    = state_q == REQ;
  assign buf_ld    = state_q == LOAD;
  assign win_valid = state_q == SWEEP;
  assign done      = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign buf_row   = row_q;
  assign buf_col   = col_q;
  assign buf_data  = data_q;
  assign buf_index = index_q;
`ifdef WFC_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE && start)) stall_q <= '0;
    else if (state_q == SWEEP && !win_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_window_fill_ctrl.sv
// tb_window_fill_ctrl: scoreboard bench for window_fill_ctrl (fill order, backpressure, wrap, latency, reset).
module tb_window_fill_ctrl;
  localparam int AW = 16;
  logic clk = 0, rst = 1, start = 0, mem_rvalid = 0, win_ready = 1;
  logic [AW-1:0] base_addr = '0;
  logic [31:0] mem_rdata = '0;
  logic busy, done, mem_rd, buf_ld, win_valid;
  logic [AW-1:0] mem_addr;
  logic [1:0] buf_row, buf_col;
  logic [31:0] buf_data;
  logic [3:0] buf_index;
`ifdef WFC_STALL_CNT_EN
  logic [15:0] stall_cnt;
  int st_done = 0;
`endif
  typedef struct {
    logic [1:0]  row;
    logic [1:0]  col;
    logic [31:0] data;
  } ld_t;
  logic [AW-1:0] exp_addr[$];
  ld_t exp_ld[$];
  logic [AW-1:0] addr_log[16];
  int tests = 0, fails = 0, cyc = 0;
  int lat_mode = 0, ready_mode = 0;
  bit spur = 0;
  int n_sweep = 0, n_acc = 0, n_done = 0, n_rd = 0, wv_rise = 0;
  logic [3:0] exp_idx = 4'd3;
  bit wv_prev = 0;

  window_fill_ctrl #(.ADDR_W(AW), .ROW_STRIDE(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .buf_ld(buf_ld), .buf_row(buf_row), .buf_col(buf_col), .buf_data(buf_data),
    .buf_index(buf_index), .win_valid(win_valid), .win_ready(win_ready)
`ifdef WFC_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory model: answers each read with the address as data after lat cycles.
  initial forever begin
    logic [AW-1:0] a;
    int l;
    @(negedge clk);
    if (mem_rd) begin
      a = mem_addr;
      l = (lat_mode == 1) ? int'($urandom_range(1, 5)) : (lat_mode == 0 ? 1 : 4);
      if (spur) begin
        mem_rvalid = 1;
        mem_rdata = 32'hDEADBEEF;
      end
      @(posedge clk);
      #1 mem_rvalid = 0;
      repeat (l - 1) begin
        @(posedge clk);
        #1;
      end
      mem_rvalid = 1;
      mem_rdata = 32'(a);
      @(posedge clk);
      #1 mem_rvalid = 0;
      mem_rdata = '0;
    end else if (spur && win_valid) begin
      mem_rvalid = 1;
      mem_rdata = 32'hDEADBEEF;
      @(posedge clk);
      #1 mem_rvalid = 0;
    end
  end

  // Window sink: mode 0 always ready, 1 ready on alternate SWEEP cycles, 2 holds off 7 cycles at index 9.
  initial begin
    int sc, lown;
    sc = 0;
    lown = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!win_valid) begin
        sc = 0;
        lown = 0;
        win_ready = 1;
      end else begin
        if (ready_mode == 1) win_ready = (sc % 2 == 0);
        else if (ready_mode == 2) begin
          win_ready = !(buf_index == 4'd9 && lown < 7);
          if (!win_ready) lown++;
        end else win_ready = 1;
        sc++;
      end
    end
  end

  // Monitor: pops the scoreboard on every read and load, tracks the sweep.
  initial forever begin
    @(negedge clk);
    if (mem_rd) begin
      addr_log[n_rd % 16] = mem_addr;
      n_rd++;
      chk("rd_expected", 32'(exp_addr.size() > 0), 1);
      if (exp_addr.size() > 0) chk("rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
    end
    if (buf_ld) begin
      chk("ld_expected", 32'(exp_ld.size() > 0), 1);
      if (exp_ld.size() > 0) begin
        ld_t e;
        e = exp_ld.pop_front();
        chk("ld_row", 32'(buf_row), 32'(e.row));
        chk("ld_col", 32'(buf_col), 32'(e.col));
        chk("ld_data", buf_data, e.data);
      end
    end
    if (win_valid) begin
      if (!wv_prev) begin
        wv_rise = cyc;
        exp_idx = 4'd3;
      end
      n_sweep++;
      if (win_ready) begin
        chk("win_index", 32'(buf_index), 32'(exp_idx));
        exp_idx++;
        n_acc++;
      end
    end
    wv_prev = win_valid;
    if (done) n_done++;
  end

  task automatic push_tile(input logic [AW-1:0] b);
    for (int k = 0; k < 16; k++) begin
      ld_t e;
      logic [AW-1:0] a;
      a = b + AW'((k / 4) * 16 + (k % 4));
      e.row = 2'(k / 4);
      e.col = 2'(k % 4);
      e.data = 32'(a);
      exp_addr.push_back(a);
      exp_ld.push_back(e);
    end
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_busy"}, 32'(busy), 0);
    chk({t, "_done"}, 32'(done), 0);
    chk({t, "_mem_rd"}, 32'(mem_rd), 0);
    chk({t, "_mem_addr"}, 32'(mem_addr), 0);
    chk({t, "_buf_ld"}, 32'(buf_ld), 0);
    chk({t, "_buf_row"}, 32'(buf_row), 0);
    chk({t, "_buf_col"}, 32'(buf_col), 0);
    chk({t, "_buf_data"}, buf_data, 0);
    chk({t, "_buf_index"}, 32'(buf_index), 3);
    chk({t, "_win_valid"}, 32'(win_valid), 0);
  endtask

  task automatic run_tile(input logic [AW-1:0] b, input bit timing, input int exp_sw);
    int sw0, acc0, dn0, ts, td, n;
    sw0 = n_sweep;
    acc0 = n_acc;
    dn0 = n_done;
    td = 0;
    push_tile(b);
    @(negedge clk);
    start = 1;
    base_addr = b;
    @(posedge clk);
    #1 ts = cyc - 1;
    start = 0;
    base_addr = AW'($urandom);
`ifdef WFC_STALL_CNT_EN
    chk("stall_clr", 32'(stall_cnt), 0);
`endif
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (done) begin
        td = cyc;
`ifdef WFC_STALL_CNT_EN
        st_done = int'(stall_cnt);
`endif
        break;
      end
      if (spur) start = (n % 5 == 2);
      n++;
    end
    start = 0;
    chk("done_seen", 32'(td != 0), 1);
    if (timing) begin
      chk("first_wv_t", 32'(wv_rise - ts), 49);
      chk("done_t", 32'(td - ts), 62);
    end
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 0);
    chk("done_one_cycle", 32'(done), 0);
    repeat (5) @(negedge clk);
    chk("no_extra_tile", 32'(busy), 0);
    chk("sweep_cycles", 32'(n_sweep - sw0), 32'(exp_sw));
    chk("accepts", 32'(n_acc - acc0), 13);
    chk("done_pulses", 32'(n_done - dn0), 1);
    chk("rd_left", 32'(exp_addr.size()), 0);
    chk("ld_left", 32'(exp_ld.size()), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst = 0;
    run_tile(16'h0100, 1, 13);
    ready_mode = 1;
    run_tile(16'h0200, 0, 25);
    ready_mode = 0;
    run_tile(16'hFFF0, 1, 13);
    chk("wrap_r1c0", 32'(addr_log[4]), 32'h0000);
    chk("wrap_r1c3", 32'(addr_log[7]), 32'h0003);
    chk("wrap_r3c0", 32'(addr_log[12]), 32'h0020);
    chk("wrap_r3c3", 32'(addr_log[15]), 32'h0023);
    lat_mode = 1;
    spur = 1;
    run_tile(16'h1234, 0, 13);
    spur = 0;
    lat_mode = 4;
    exp_addr.push_back(16'h0300);
    @(negedge clk);
    start = 1;
    base_addr = 16'h0300;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("rst_pre_busy", 32'(busy), 1);
    rst = 1;
    @(negedge clk);
    chk_rst("midrst");
    rst = 0;
    repeat (8) @(negedge clk);
    chk("midrst_idle", 32'(busy), 0);
    chk("midrst_rd_left", 32'(exp_addr.size()), 0);
    lat_mode = 0;
    run_tile(16'h0400, 1, 13);
`ifdef WFC_STALL_CNT_EN
    ready_mode = 2;
    run_tile(16'h0500, 0, 20);
    chk("stall_at_done", 32'(st_done), 7);
    ready_mode = 0;
    run_tile(16'h0600, 1, 13);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/window_fill_ctrl.md
# window_fill_ctrl

Sequencer for the 4×16 byte line buffer in the convolution datapath. On a start pulse it fetches a 4-row × 4-word (32-bit) tile from word-addressed memory and drives the buffer's load port one word at a time. It then sweeps the buffer's window index from 3 to 15, presenting one 4×4 byte window per step to the downstream MAC through a valid/ready handshake.

## Interface
- ADDR_W, 16, memory word-address width
- ROW_STRIDE, 16, word distance between consecutive image rows
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset; synchronous, active-high; returns block to IDLE
- start  input  1  begin a tile; sampled only in IDLE
- base_addr  input  ADDR_W  word address of tile row 0, column 0; captured on start acceptance
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last window is accepted
- mem_rd  output  1  read request, one cycle per word
- mem_addr  output  ADDR_W  read address, valid while mem_rd is high
- mem_rvalid  input  1  read data valid; earliest one cycle after mem_rd
- mem_rdata  input  32  read data
- buf_ld  output  1  buffer load strobe
- buf_row  output  2  buffer row for the load
- buf_col  output  2  buffer 4-byte column group for the load
- buf_data  output  32  registered load data
- buf_index  output  4  window index driven to the buffer
- win_valid  output  1  buffer output holds a valid window
- win_ready  input  1  downstream accepts the window

## Operation
- States: IDLE, REQ, WAIT, LOAD, SWEEP, DONE.
- Word counter k[3:0]: row = k[3:2], col = k[1:0].
- IDLE:
  - start=1 → capture base_addr, set k=0, go to REQ.
  - start in any other state is ignored.
- REQ:
  - mem_rd=1, mem_addr = base + row·ROW_STRIDE + col, computed modulo 2^ADDR_W (address wraps, no error).
  - Next state WAIT.
- WAIT:
  - Hold until mem_rvalid.
  - On mem_rvalid: register mem_rdata into buf_data, go to LOAD.
  - mem_rvalid in any state other than WAIT is ignored.
  - No timeout; a missing response stalls the block until rst.
- LOAD:
  - buf_ld=1, buf_row/buf_col from k.
  - If k=15 → go to SWEEP with buf_index=3; otherwise k+1 → REQ.
- SWEEP:
  - win_valid=1.
  - On win_valid&&win_ready:
    - buf_index=15 → go to DONE.
    - Otherwise buf_index+1.
  - buf_index is held stable while win_ready=0.
- DONE: done=1 for one cycle, then IDLE. A start in the DONE cycle is ignored.
- Output timing: buf_row, buf_col and buf_index are registered. buf_ld, mem_rd, win_valid, done and busy decode the current state.
- Reset values: mem_rd=0, mem_addr=0, buf_ld=0, buf_row=0, buf_col=0, buf_data=0, buf_index=3, win_valid=0, done=0, busy=0. Internal k=0, captured base=0.
- rst at any point, including mid-fill or mid-sweep, aborts the tile; a read response that is still outstanding is discarded. Buffer contents are not cleared by this block.

## Timing
- start accepted at edge T: REQ in cycle T+1.
- With 1-cycle memory latency, each word takes 3 cycles (REQ, WAIT, LOAD).
- Fill takes 48 cycles; first win_valid in cycle T+49.
- With win_ready held high, 13 windows take 13 cycles; done in cycle T+62; IDLE at T+63.
- Each extra cycle of memory latency adds 16 cycles; each win_ready-low cycle adds 1 cycle.

## Configuration
- WFC_STALL_CNT_EN defined:
  - Adds output stall_cnt[15:0], reset to 0 and cleared on start acceptance.
  - Increments in each SWEEP cycle with win_valid=1 and win_ready=0.
  - Saturates at 16'hFFFF.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Fill order:
  - Stimulus: base_addr=0x0100, 1-cycle memory returning the address as data.
  - Required: 16 mem_rd at 0x0100–0x0103, 0x0110–0x0113, 0x0120–0x0123, 0x0130–0x0133.
  - Required: buf_ld row/col follows (0,0)…(3,3) with matching buf_data; win_valid first seen 49 cycles after start.
- Sweep with backpressure:
  - Stimulus: win_ready low on every other cycle.
  - Required: buf_index steps 3..15 only on accepts, 13 accepts total, 25 SWEEP cycles, one done pulse, busy low the cycle after done.
- Address wrap:
  - Stimulus: base_addr=0xFFF0, ROW_STRIDE=16.
  - Required: row-1 reads at 0x0000–0x0003 and row-3 reads at 0x0020–0x0023.
- Variable latency and ignored inputs:
  - Stimulus: mem_rvalid at 1–5 cycles after each mem_rd; spurious mem_rvalid pulses during REQ and SWEEP; start pulses while busy.
  - Required: load order and data unchanged; no extra tile is started.
- Reset mid-operation:
  - Stimulus: rst during WAIT with a read outstanding, then the late mem_rvalid arrives.
  - Required: all outputs return to their reset values next cycle; no buf_ld is issued; a fresh start then completes a normal tile.
- Stall counter (WFC_STALL_CNT_EN defined):
  - Stimulus: win_ready held low for 7 cycles at index 9.
  - Required: stall_cnt=7 at done; stall_cnt cleared to 0 on the next start.
